arc4_key_search: RTL

- Parametrised multi-lane key-search controller for the ARC4 cracker.
- Hands out candidate keys to NUM_LANES independent ARC4 decrypt lanes. Each lane decrypts the ciphertext with its key and reports whether the plaintext passed the printable check.
- Stops on the first reported match or when the keyspace is exhausted, then returns key/key_valid to the top level.
- Sits between the top-level task FSM and the lane array. Replaces the single-lane, fixed 24-bit controller.

---
 rtl/arc4_key_search_pkg.sv | 16 +
 rtl/arc4_key_search_lane_arbiter.sv | 28 ++
 rtl/arc4_key_search.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/arc4_key_search_pkg.sv
// Shared definitions for the ARC4 key-search controller: controller
// states and the "no key" marker driven on key when no match exists.
package arc4_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        RUN,
        DRAIN,
        DONE
    } search_state_e;

    // Wide enough for any supported KEY_W; users slice the low KEY_W bits.
    localparam logic [63:0] KEY_ALL_ONES = {64{1'b1}};

endpackage

// File: rtl/arc4_key_search_lane_arbiter.sv
// Lowest-index-first picker. Given a request vector it returns a one-hot
// grant, the granted index and whether any request was present.
module lane_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest requesting index is the last write.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arc4_key_search.sv
// Multi-lane ARC4 key-search controller. Hands one candidate key per cycle
// to the lowest free decrypt lane, stops on the first reported match or on
// keyspace exhaustion, drains outstanding lanes and reports key/key_valid.
// Optional build macro ARC4_SEARCH_STATS_EN adds the keys_tried counter.
module arc4_key_search
    import arc4_search_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int KEY_W      = 24,
    parameter int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic                       rdy,
    input  logic [KEY_W-1:0]           starting_key,
    input  logic [KEY_W-1:0]           key_increment,
    output logic [KEY_W-1:0]           key,
    output logic                       key_valid,
    output logic [LANE_IDX_W-1:0]      match_lane,
    output logic [NUM_LANES-1:0]       lane_start,
    output logic [NUM_LANES*KEY_W-1:0] lane_key,
    input  logic [NUM_LANES-1:0]       lane_done,
    input  logic [NUM_LANES-1:0]       lane_match
`ifdef ARC4_SEARCH_STATS_EN
    ,
    output logic [KEY_W:0]             keys_tried
`endif
);

    localparam logic [KEY_W-1:0] ALL_ONES = KEY_ALL_ONES[KEY_W-1:0];

    search_state_e state_q, state_d;
    // MSB of next_key is the exhausted flag: the carry out of the keyspace.
    logic [KEY_W:0]             next_key_q, next_key_d;
    logic [KEY_W-1:0]           stride_q, stride_d;
    logic [NUM_LANES-1:0]       busy_q, busy_d;
    logic                       found_q, found_d;
    logic [KEY_W-1:0]           key_q, key_d;
    logic                       key_valid_q, key_valid_d;
    logic [LANE_IDX_W-1:0]      match_lane_q, match_lane_d;
    logic [NUM_LANES-1:0]       lane_start_q, lane_start_d;
    logic [NUM_LANES*KEY_W-1:0] lane_key_q, lane_key_d;
    logic                       rdy_q, rdy_d;

    logic [NUM_LANES-1:0]  done_ok, busy_clr, match_req;
    logic [NUM_LANES-1:0]  free_gnt, match_gnt;
    logic [LANE_IDX_W-1:0] free_idx, match_idx;
    logic                  free_any, match_any;
    logic [KEY_W-1:0]      match_key;

    // Completions only count for busy lanes; a lane finishing this cycle is
    // already free for the dispatch decision made in the same cycle.
    assign done_ok   = lane_done & busy_q;
    assign busy_clr  = busy_q & ~done_ok;
    assign match_req = done_ok & lane_match;

    lane_arbiter #(.N(NUM_LANES), .IDX_W(LANE_IDX_W)) u_free_pick (
        .req (~busy_clr),
        .gnt (free_gnt),
        .idx (free_idx),
        .any (free_any)
    );

    lane_arbiter #(.N(NUM_LANES), .IDX_W(LANE_IDX_W)) u_match_pick (
        .req (match_req),
        .gnt (match_gnt),
        .idx (match_idx),
        .any (match_any)
    );

    // Key held by the winning matching lane.
    always_comb begin
        match_key = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (match_gnt[i]) begin
                match_key = match_key | lane_key_q[i*KEY_W +: KEY_W];
            end
        end
    end

    // Next-state, dispatch and match-latch logic.
    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        stride_d     = stride_q;
        busy_d       = busy_clr;
        found_d      = found_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        match_lane_d = match_lane_q;
        lane_start_d = '0;
        lane_key_d   = lane_key_q;
        rdy_d        = rdy_q;

        if (match_any && !found_q) begin
            found_d      = 1'b1;
            key_d        = match_key;
            match_lane_d = match_idx;
        end

        unique case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (en) begin
                    next_key_d  = {1'b0, starting_key};
                    stride_d    = (key_increment == '0) ? KEY_W'(1) : key_increment;
                    found_d     = 1'b0;
                    key_valid_d = 1'b0;
                    key_d       = ALL_ONES;
                    rdy_d       = 1'b0;
                    state_d     = DISPATCH;
                end
            end
            DISPATCH, RUN: begin
                if (free_any && !found_q && !next_key_q[KEY_W]) begin
                    lane_start_d = free_gnt;
                    busy_d       = busy_clr | free_gnt;
                    lane_key_d[int'(free_idx)*KEY_W +: KEY_W] = next_key_q[KEY_W-1:0];
                    next_key_d   = next_key_q + {1'b0, stride_q};
                end
                state_d = (found_d || next_key_d[KEY_W]) ? DRAIN : RUN;
            end
            DRAIN: begin
                if (busy_clr == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                key_valid_d = found_q;
                rdy_d       = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            next_key_q   <= '0;
            stride_q     <= KEY_W'(1);
            busy_q       <= '0;
            found_q      <= 1'b0;
            key_q        <= ALL_ONES;
            key_valid_q  <= 1'b0;
            match_lane_q <= '0;
            lane_start_q <= '0;
            lane_key_q   <= '0;
            rdy_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            stride_q     <= stride_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            match_lane_q <= match_lane_d;
            lane_start_q <= lane_start_d;
            lane_key_q   <= lane_key_d;
            rdy_q        <= rdy_d;
        end
    end

    assign rdy        = rdy_q;
    assign key_valid  = key_valid_q;
    assign key        = key_valid_q ? key_q : ALL_ONES;
    assign match_lane = match_lane_q;
    assign lane_start = lane_start_q;
    assign lane_key   = lane_key_q;

`ifdef ARC4_SEARCH_STATS_EN
    logic [KEY_W:0] keys_tried_q, keys_tried_d;
    logic [4:0]     done_cnt;

    function automatic logic [KEY_W:0] sat_add(input logic [KEY_W:0] a, input logic [4:0] b);
        logic [KEY_W+1:0] s;
        s = {1'b0, a} + (KEY_W+2)'(b);
        return s[KEY_W+1] ? {(KEY_W+1){1'b1}} : s[KEY_W:0];
    endfunction

    // Count accepted completions; cleared when a new search is accepted.
    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            done_cnt = done_cnt + 5'(done_ok[i]);
        end
        keys_tried_d = sat_add(keys_tried_q, done_cnt);
        if (state_q == IDLE && en) begin
            keys_tried_d = '0;
        end
    end

    // Completion counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_tried_q <= '0;
        end else begin
            keys_tried_q <= keys_tried_d;
        end
    end

    assign keys_tried = keys_tried_q;
`endif

endmodule
